// File: rtl/rv_multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 control slice.
// Holds opcode constants, select-code constants and the FSM state encoding.
package rv_multicycle_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_U    = 3'd5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

endpackage

// File: rtl/rv_multicycle_ctrl_decode.sv
// Combinational decoder: opcode/funct fields to datapath selects, instruction
// class flags and an illegal flag for anything outside the supported subset.
// Ports:
//   opcode, funct3, funct7      in  instruction fields
//   immsel, asel, bsel, alusel  out datapath selects
//   wbsel                       out write-back source
//   is_load/is_store/is_branch/is_jal/is_jalr  out instruction class
//   writes                      out instruction writes rd in EXEC
//   illegal                     out unsupported opcode/funct
module rv_ctrl_decode
  import rv_multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] immsel,
  output logic       asel,
  output logic       bsel,
  output logic [2:0] alusel,
  output logic [1:0] wbsel,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jal,
  output logic       is_jalr,
  output logic       writes,
  output logic       illegal
);

  always_comb begin
    immsel    = IMM_NONE;
    asel      = 1'b0;
    bsel      = 1'b0;
    alusel    = ALU_ADD;
    wbsel     = WB_ALU;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    writes    = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_R: begin
        asel   = 1'b1;
        bsel   = 1'b1;
        writes = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: alusel = ALU_ADD;
          {7'b0100000, 3'b000}: alusel = ALU_SUB;
          {7'b0000000, 3'b111}: alusel = ALU_AND;
          {7'b0000000, 3'b110}: alusel = ALU_OR;
          {7'b0000000, 3'b100}: alusel = ALU_XOR;
          default:              illegal = 1'b1;
        endcase
      end
      OP_I: begin
        immsel = IMM_I;
        asel   = 1'b1;
        writes = 1'b1;
        case (funct3)
          3'b000:  alusel = ALU_ADD;
          3'b111:  alusel = ALU_AND;
          3'b110:  alusel = ALU_OR;
          3'b100:  alusel = ALU_XOR;
          default: illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        immsel  = IMM_I;
        asel    = 1'b1;
        wbsel   = WB_MEM;
        is_load = 1'b1;
        illegal = (funct3 != 3'b010);
      end
      OP_STORE: begin
        immsel   = IMM_S;
        asel     = 1'b1;
        is_store = 1'b1;
        illegal  = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        immsel    = IMM_B;
        is_branch = 1'b1;
        case (funct3)
          3'b000, 3'b001, 3'b100, 3'b101: illegal = 1'b0;
          default:                        illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        immsel = IMM_J;
        wbsel  = WB_PC4;
        is_jal = 1'b1;
        writes = 1'b1;
      end
      OP_JALR: begin
        immsel  = IMM_I;
        asel    = 1'b1;
        wbsel   = WB_PC4;
        is_jalr = 1'b1;
        writes  = 1'b1;
        illegal = (funct3 != 3'b000);
      end
      OP_LUI: begin
        // rs1 is forced to x0 on the ins bus, so rs1 + U-imm gives the LUI value
        immsel = IMM_U;
        asel   = 1'b1;
        writes = 1'b1;
      end
      OP_AUIPC: begin
        immsel = IMM_U;
        writes = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> (MEM -> WB) -> FETCH.
// Owns the PC, latched instruction, retired-instruction counter and sticky
// trap flag; drives datapath selects and the imem/dmem handshakes.
// Ports:
//   clk, rst                 clock, async active-high reset
//   imem_req/ready/rdata     instruction fetch handshake (pc is the address)
//   ins, pc                  latched instruction and current PC
//   regwen, immsel, asel, bsel, alusel, wbsel   datapath controls
//   alu_res, breq, brlt      datapath results back to control
//   dmem_req/we/ready        data access handshake (alu_res is the address)
//   illegal, instret         sticky trap flag, retired-instruction count
module rv_multicycle_ctrl
  import rv_multicycle_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic        ALIGN_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic        regwen,
  output logic [2:0]  immsel,
  output logic        asel,
  output logic        bsel,
  output logic [2:0]  alusel,
  output logic [1:0]  wbsel,
  input  logic [31:0] alu_res,
  input  logic        breq,
  input  logic        brlt,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        illegal,
  output logic [31:0] instret
);

  state_t      state, state_nxt;
  logic [31:0] ins_q;
  logic [31:0] pc_target;
  logic        pc_load;
  logic        br_taken;

  logic [2:0] d_immsel, d_alusel;
  logic [1:0] d_wbsel;
  logic       d_asel, d_bsel, d_load, d_store, d_branch, d_jal, d_jalr;
  logic       d_writes, d_illegal;

  rv_ctrl_decode u_dec (
    .opcode    (ins_q[6:0]),
    .funct3    (ins_q[14:12]),
    .funct7    (ins_q[31:25]),
    .immsel    (d_immsel),
    .asel      (d_asel),
    .bsel      (d_bsel),
    .alusel    (d_alusel),
    .wbsel     (d_wbsel),
    .is_load   (d_load),
    .is_store  (d_store),
    .is_branch (d_branch),
    .is_jal    (d_jal),
    .is_jalr   (d_jalr),
    .writes    (d_writes),
    .illegal   (d_illegal)
  );

  // funct3[2] picks lt vs eq, funct3[0] inverts (bne/bge)
  assign br_taken = (ins_q[14] ? brlt : breq) ^ ins_q[12];

  assign ins = (ins_q[6:0] == OP_LUI) ? {ins_q[31:20], 5'd0, ins_q[14:0]} : ins_q;

  always_comb begin
    state_nxt = state;
    pc_target = pc + 32'd4;
    pc_load   = 1'b0;
    regwen    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    immsel    = IMM_NONE;
    asel      = 1'b0;
    bsel      = 1'b0;
    alusel    = ALU_ADD;
    wbsel     = WB_ALU;
    // Selects stay decoded from DECODE through WB so alu_res is stable
    // for the whole instruction, including the MEM address.
    if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) begin
      immsel = d_immsel;
      asel   = d_asel;
      bsel   = d_bsel;
      alusel = d_alusel;
      wbsel  = d_wbsel;
    end
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = d_illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (d_load || d_store) begin
          state_nxt = S_MEM;
        end else begin
          pc_load   = 1'b1;
          regwen    = d_writes;
          state_nxt = S_FETCH;
          if (d_jal)                      pc_target = alu_res;
          else if (d_jalr)                pc_target = alu_res & ~32'd1;
          else if (d_branch && br_taken)  pc_target = alu_res;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = d_store;
        if (dmem_ready) begin
          if (d_store) begin
            pc_load   = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        regwen    = 1'b1;
        wbsel     = WB_MEM;
        pc_load   = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_TRAP;
    endcase
    // Misaligned target: keep the old PC, drop the write, park in TRAP
    if (ALIGN_TRAP && pc_load && (pc_target[1:0] != 2'b00)) begin
      pc_load   = 1'b0;
      regwen    = 1'b0;
      state_nxt = S_TRAP;
    end
    // rst is async; kill strobes combinationally so nothing leaks this cycle
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      regwen   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ins_q   <= '0;
      instret <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && imem_ready) ins_q <= imem_rdata;
      if (pc_load) begin
        pc      <= pc_target;
        instret <= instret + 32'd1;
      end
      if (state_nxt == S_TRAP) illegal <= 1'b1;
    end
  end

endmodule
